rom_bus_bridge: RTL and testbench

Bridges the Z80 CPU memory bus to the synchronous, one-cycle-latency ROM block. The bridge works as follows:
- Decodes CPU memory reads that fall inside the ROM window.
- Issues the ROM enable/address.
- Stretches the CPU cycle with WAIT until the registered ROM data is available.
- Drives the captured byte back onto the CPU read-data path.

It sits between the CPU bus interface (upstream) and the ROM instance (downstream).

---
 rtl/rom_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_rom_bus_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_bridge.sv
// Z80 memory-read bridge to a synchronous, one-cycle-latency ROM. It holds the CPU
// in WAIT until the registered ROM byte is captured, then drives that byte back.
module rom_bus_bridge #(
    parameter int          ADDR_W     = 14,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          EXTRA_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_rfsh_n,
    output logic              cpu_wait_n,
    output logic [7:0]        cpu_dout,
    output logic              cpu_dout_en,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_dout
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        STRETCH,
        HOLD
    } state_t;

    // STRETCH counts down to zero, so it is loaded with one less than the extra cycles.
    localparam logic [3:0] CNT_LOAD = (EXTRA_WAIT > 0) ? 4'(EXTRA_WAIT - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              wait_n_nxt;
    logic [7:0]        dout_nxt;
    logic              dout_en_nxt;
    logic              rom_ena_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;

    logic req;
    logic hit;

    assign req = !cpu_mreq_n && !cpu_rd_n;
    assign hit = req && cpu_rfsh_n && (cpu_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cpu_wait_n  <= 1'b1;
            cpu_dout    <= 8'h00;
            cpu_dout_en <= 1'b0;
            rom_ena     <= 1'b0;
            rom_addr    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cpu_wait_n  <= wait_n_nxt;
            cpu_dout    <= dout_nxt;
            cpu_dout_en <= dout_en_nxt;
            rom_ena     <= rom_ena_nxt;
            rom_addr    <= rom_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        wait_n_nxt   = cpu_wait_n;
        dout_nxt     = cpu_dout;
        dout_en_nxt  = cpu_dout_en;
        rom_ena_nxt  = rom_ena;
        rom_addr_nxt = rom_addr;

        case (state)
            IDLE: begin
                if (hit) begin
                    rom_addr_nxt = cpu_addr[ADDR_W-1:0];
                    rom_ena_nxt  = 1'b1;
                    wait_n_nxt   = 1'b0;
                    state_nxt    = ISSUE;
                end
            end

            ISSUE: begin
                if (!req) begin
                    rom_ena_nxt = 1'b0;
                    wait_n_nxt  = 1'b1;
                    dout_en_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    rom_ena_nxt = 1'b0;
                    state_nxt   = CAPTURE;
                end
            end

            // An abandoned cycle must leave the previously captured byte untouched.
            CAPTURE: begin
                if (!req) begin
                    rom_ena_nxt = 1'b0;
                    wait_n_nxt  = 1'b1;
                    dout_en_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    dout_nxt = rom_dout;
                    if (EXTRA_WAIT == 0) begin
                        wait_n_nxt  = 1'b1;
                        dout_en_nxt = 1'b1;
                        state_nxt   = HOLD;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = STRETCH;
                    end
                end
            end

            STRETCH: begin
                if (!req) begin
                    rom_ena_nxt = 1'b0;
                    wait_n_nxt  = 1'b1;
                    dout_en_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else if (cnt == 4'd0) begin
                    wait_n_nxt  = 1'b1;
                    dout_en_nxt = 1'b1;
                    state_nxt   = HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            HOLD: begin
                if (!req) begin
                    dout_en_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_bus_bridge.sv
// Bench for rom_bus_bridge: two bridges (window 0x0000/no stretch, window 0x4000/3 extra
// waits) share one CPU bus and are compared every cycle against a read-timeline model.
module tb_rom_bus_bridge;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [15:0] cpu_addr   = 16'h0000;
    logic        cpu_mreq_n = 1'b1;
    logic        cpu_rd_n   = 1'b1;
    logic        cpu_rfsh_n = 1'b1;

    logic        wait_n   [2];
    logic [7:0]  dout     [2];
    logic        dout_en  [2];
    logic        rom_ena  [2];
    logic [13:0] rom_addr [2];
    logic [7:0]  rom_dout [2] = '{8'h00, 8'h00};

    logic [7:0]  rom_mem [0:16383];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rom_bus_bridge #(.ADDR_W(14), .BASE_ADDR(16'h0000), .EXTRA_WAIT(0)) u_lo (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(wait_n[0]),
        .cpu_dout(dout[0]), .cpu_dout_en(dout_en[0]), .rom_ena(rom_ena[0]),
        .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0])
    );

    rom_bus_bridge #(.ADDR_W(14), .BASE_ADDR(16'h4000), .EXTRA_WAIT(3)) u_hi (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(wait_n[1]),
        .cpu_dout(dout[1]), .cpu_dout_en(dout_en[1]), .rom_ena(rom_ena[1]),
        .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1])
    );

    // Synchronous ROMs: byte appears the cycle after enable.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rom_ena[i]) rom_dout[i] <= rom_mem[rom_addr[i]];
    end

    function automatic int ew_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [1:0] win_of(input int i);
        return (i == 0) ? 2'b00 : 2'b01;
    endfunction

    // Model: each accepted read is tracked by its age in cycles since acceptance.
    logic        m_active [2];
    int          m_age    [2];
    logic [13:0] m_addr   [2];
    logic [7:0]  m_dout   [2];

    always @(posedge clk or posedge rst) begin
        logic req;
        req = !cpu_mreq_n && !cpu_rd_n;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_age[i]    <= 0;
                m_addr[i]   <= 14'h0000;
                m_dout[i]   <= 8'h00;
            end else if (!m_active[i]) begin
                if (req && cpu_rfsh_n && cpu_addr[15:14] == win_of(i)) begin
                    m_active[i] <= 1'b1;
                    m_age[i]    <= 1;
                    m_addr[i]   <= cpu_addr[13:0];
                end
            end else if (!req) begin
                m_active[i] <= 1'b0;
            end else begin
                if (m_age[i] == 2) m_dout[i] <= rom_mem[m_addr[i]];
                if (m_age[i] < 3 + ew_of(i)) m_age[i] <= m_age[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("u%0d rom_ena", i), 32'(rom_ena[i]),
                            32'(m_active[i] && m_age[i] == 1));
                checkOutput($sformatf("u%0d wait_n", i), 32'(wait_n[i]),
                            32'(!(m_active[i] && m_age[i] <= 2 + ew_of(i))));
                checkOutput($sformatf("u%0d dout_en", i), 32'(dout_en[i]),
                            32'(m_active[i] && m_age[i] >= 3 + ew_of(i)));
                checkOutput($sformatf("u%0d rom_addr", i), 32'(rom_addr[i]), 32'(m_addr[i]));
                checkOutput($sformatf("u%0d dout", i), 32'(dout[i]), 32'(m_dout[i]));
            end
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic mreq_n,
                                 input logic rd_n, input logic rfsh_n);
        cpu_addr   = a;
        cpu_mreq_n = mreq_n;
        cpu_rd_n   = rd_n;
        cpu_rfsh_n = rfsh_n;
    endtask

    task automatic busIdle();
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1);
    endtask

    // One complete read on bridge i, with hand-derived latency and wait length.
    task automatic runRead(input int i, input logic [15:0] a, input logic [13:0] exp_addr,
                           input logic [7:0] exp_data, input int hold_extra);
        int   cycles = 0;
        int   low    = 0;
        int   pulses = 0;
        logic done   = 1'b0;
        applyStimulus(a, 1'b0, 1'b0, 1'b1);
        while (!done && cycles < 30) begin
            nextCycle();
            cycles++;
            if (!wait_n[i]) low++;
            if (rom_ena[i]) pulses++;
            if (cycles == 1) checkOutput("read rom_addr", 32'(rom_addr[i]), 32'(exp_addr));
            if (dout_en[i]) done = 1'b1;
        end
        checkOutput("read completes in budget", 32'(done), 32'd1);
        checkOutput("read latency", cycles, 3 + ew_of(i));
        checkOutput("read wait_n low cycles", low, 2 + ew_of(i));
        checkOutput("read data", 32'(dout[i]), 32'(exp_data));
        repeat (hold_extra) begin
            nextCycle();
            if (rom_ena[i]) pulses++;
            checkOutput("hold dout_en", 32'(dout_en[i]), 32'd1);
        end
        checkOutput("rom_ena pulses", pulses, 1);
        busIdle();
        nextCycle();
        checkOutput("dout_en drop", 32'(dout_en[i]), 32'd0);
        checkOutput("dout kept", 32'(dout[i]), 32'(exp_data));
    endtask

    initial begin
        logic [7:0]  saved;
        logic [15:0] a;
        int          len;
        logic [15:0] pats [4];

        for (int k = 0; k < 16384; k++) begin
            logic [13:0] kk;
            kk = 14'(k);
            rom_mem[k] = kk[7:0] ^ {kk[13:8], 2'b00};
        end
        rom_mem[14'h0123] = 8'hA5;
        rom_mem[14'h3FFF] = 8'h5C;

        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset rom_ena", 32'(rom_ena[i]), 32'd0);
            checkOutput("reset wait_n", 32'(wait_n[i]), 32'd1);
            checkOutput("reset dout_en", 32'(dout_en[i]), 32'd0);
            checkOutput("reset dout", 32'(dout[i]), 32'h00);
            checkOutput("reset rom_addr", 32'(rom_addr[i]), 32'h0000);
        end
        nextCycle();

        runRead(0, 16'h0123, 14'h0123, 8'hA5, 0);
        runRead(1, 16'h4010, 14'h0010, 8'h10, 2);
        runRead(1, 16'h7FFF, 14'h3FFF, 8'h5C, 0);

        pats[0] = 16'h3FFF;
        pats[1] = 16'hC000;
        pats[2] = 16'h4000;
        pats[3] = 16'h4000;
        for (int p = 0; p < 4; p++) begin
            if (p == 2)      applyStimulus(pats[p], 1'b0, 1'b0, 1'b0);
            else if (p == 3) applyStimulus(pats[p], 1'b0, 1'b1, 1'b1);
            else             applyStimulus(pats[p], 1'b0, 1'b0, 1'b1);
            repeat (4) begin
                nextCycle();
                checkOutput("window no rom_ena", 32'(rom_ena[1]), 32'd0);
                checkOutput("window no wait", 32'(wait_n[1]), 32'd1);
            end
            busIdle();
            repeat (2) nextCycle();
        end

        saved = dout[0];
        applyStimulus(16'h0200, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("abort issue rom_ena", 32'(rom_ena[0]), 32'd1);
        busIdle();
        nextCycle();
        checkOutput("abort wait_n", 32'(wait_n[0]), 32'd1);
        checkOutput("abort dout_en", 32'(dout_en[0]), 32'd0);
        checkOutput("abort dout", 32'(dout[0]), 32'(saved));
        runRead(0, 16'h0123, 14'h0123, 8'hA5, 0);

        runRead(0, 16'h0010, 14'h0010, 8'h10, 3);
        runRead(0, 16'h0011, 14'h0011, 8'h11, 0);

        applyStimulus(16'h4020, 1'b0, 1'b0, 1'b1);
        repeat (4) nextCycle();
        checkOutput("stretch wait_n low", 32'(wait_n[1]), 32'd0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("async reset rom_ena", 32'(rom_ena[i]), 32'd0);
            checkOutput("async reset wait_n", 32'(wait_n[i]), 32'd1);
            checkOutput("async reset dout_en", 32'(dout_en[i]), 32'd0);
            checkOutput("async reset dout", 32'(dout[i]), 32'h00);
            checkOutput("async reset rom_addr", 32'(rom_addr[i]), 32'h0000);
        end
        busIdle();
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("post-reset idle wait_n", 32'(wait_n[1]), 32'd1);
        checkOutput("post-reset idle rom_ena", 32'(rom_ena[1]), 32'd0);
        runRead(1, 16'h4020, 14'h0020, rom_mem[14'h0020], 0);

        for (int n = 0; n < 400; n++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[15:14] = 2'b10;
            else                           a[15:14] = 2'($urandom_range(0, 1));
            applyStimulus(a, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) != 0);
            len = $urandom_range(1, 8);
            repeat (len) nextCycle();
            if ($urandom_range(0, 1) == 0) begin
                busIdle();
                nextCycle();
            end
        end
        busIdle();
        repeat (3) nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        tests_failed++;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
